// File: rtl/iddmm_mul_limb_serial.sv
// Limb-serial multiply-accumulate: o_result = x*y + c, exact 2*WIDTH-bit value.
// Each MUL cycle multiplies one LIMB-wide slice of x by all of y. The low limb of
// the running sum is retired into the result, and the remainder is shifted down
// into the accumulator for the next slice. After K = WIDTH/LIMB cycles, the
// accumulator's upper WIDTH bits become the top half of the result.
module iddmm_mul_limb_serial #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_x,
  input  logic [WIDTH-1:0]     i_y,
  input  logic [WIDTH-1:0]     i_c,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_result
);

  localparam int K     = WIDTH / LIMB;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = WIDTH + LIMB;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [WIDTH-1:0]      r_x;
  logic [WIDTH-1:0]      r_y;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*WIDTH-1:0]    r_result;

  logic                  w_accept;
  logic                  w_last;
  logic [LIMB-1:0]       w_limb;
  logic [ACC_W-1:0]      w_prod;
  logic [ACC_W-1:0]      w_sum;

  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_last   = (r_cnt == LAST_CNT);
  assign o_result = r_result;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; handshake outputs depend on the registered state only.
  always_comb begin
    w_next_state = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_next_state = S_MUL;
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Select the x limb for the current iteration; constant slices keep the mux explicit.
  always_comb begin
    w_limb = '0;
    for (int k = 0; k < K; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_limb = r_x[k*LIMB +: LIMB];
      end
    end
  end

  // The partial product plus carried accumulator fits in WIDTH+LIMB bits.
  assign w_prod = ACC_W'(w_limb) * ACC_W'(r_y);
  assign w_sum  = r_acc + w_prod;

  // Datapath: latch operands on acceptance, then retire one result limb per MUL cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_x      <= i_x;
      r_y      <= i_y;
      r_acc    <= ACC_W'(i_c);
      r_cnt    <= '0;
      r_result <= '0;
    end else if (r_state == S_MUL) begin
      for (int k = 0; k < K; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_result[k*LIMB +: LIMB] <= w_sum[LIMB-1:0];
        end
      end
      r_acc <= w_sum >> LIMB;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result[WIDTH +: WIDTH] <= w_sum[ACC_W-1:LIMB];
      end
    end
  end

endmodule

// File: doc/iddmm_mul_limb_serial.md
# iddmm_mul_limb_serial

Parametrised limb-serial multiply-accumulate unit computing result = x*y + c for WIDTH-bit unsigned operands, with a 2*WIDTH-bit product. It is the successor to the fixed 256x256 combinational-pipeline multiplier. It adds three things that block lacks:
- configurable operand width and limb (digit) width;
- valid/ready handshakes on input and output;
- an accumulate operand c.

It sits under the IDDMM Montgomery datapath, which uses it for the x*y and q*m + t products.

## Interface
- WIDTH, 256, operand width in bits; must be a multiple of LIMB.
- LIMB, 64, limb width in bits; one LIMB x WIDTH partial product per cycle; K = WIDTH/LIMB iterations.
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  x, y, c valid.
- in_ready  output  1  block idle and able to accept.
- x  input  WIDTH  multiplicand, unsigned.
- y  input  WIDTH  multiplier, unsigned.
- c  input  WIDTH  addend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  2*WIDTH  x*y + c, exact (no overflow possible: max value is 2^(2*WIDTH) - 2^WIDTH).

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch x, y.
  - Load accumulator acc (WIDTH+LIMB bits) with c; clear result register; cnt <= 0; go to MUL.
- MUL, once per cycle, using the right-shift scheme:
  - sum = acc + x[cnt*LIMB +: LIMB] * y. Width is WIDTH+LIMB; it cannot overflow.
  - result[cnt*LIMB +: LIMB] <= sum[LIMB-1:0].
  - acc <= sum >> LIMB.
  - cnt <= cnt + 1.
  - When cnt == K-1: write result[WIDTH +: WIDTH] <= upper WIDTH bits of sum, then go to DONE.
- DONE:
  - out_valid = 1; result held stable.
  - On out_ready go to IDLE. result keeps its value until the next acceptance clears it.
- in_ready is high only in IDLE. in_valid in MUL or DONE is ignored; the input does not need to stay stable after acceptance.
- out_valid is high only in DONE. out_ready is ignored outside DONE.
- Inputs are latched at acceptance; later changes on x, y or c do not affect the operation in flight.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE, cnt = 0, acc = 0, result = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after reset releases.
- Reset mid-operation (in MUL or DONE):
  - The operation is aborted with no output and no partial result visible.
  - All registers return to reset values on that edge.
- Latency: acceptance at edge E0; MUL occupies edges E1..EK; out_valid is high in the cycle after edge EK. That is K cycles from acceptance to out_valid (K = 4 at default parameters).
- Output hold: with out_ready held high, DONE lasts one cycle and in_ready is high in the following cycle.
- Throughput: one operation per K+2 cycles minimum. There is no overlap of output handshake and new acceptance.
- Backpressure: while out_ready is low, result and out_valid hold indefinitely and in_ready stays 0.
- in_ready and out_valid are pure functions of registered state; there is no combinational path from inputs.
- K = 1 (LIMB == WIDTH) is legal: one MUL cycle.

## Test plan
- Zero/identity, default parameters:
  - x=0, y=any, c=0 -> result 0 after 4 cycles.
  - x=1, y=0xDEADBEEF, c=5 -> result 0xDEADBEF4.
- Maximum values: x = y = c = 2^256-1 -> result = 2^512 - 2^256 (upper 256 bits all ones, lower 256 bits zero), out_valid exactly 4 cycles after acceptance.
- Random regression: 100 operations with 32-bit-chunk $random x, y, c, out_ready tied high.
  - Each result must equal the golden x*y + c.
  - in_ready must return one cycle after each output handshake.
- Backpressure and busy: hold out_ready low 5 cycles after out_valid rises, and drive in_valid high with new operands throughout MUL and DONE.
  - result stays stable and in_ready stays 0.
  - The new operands are never consumed.
  - After out_ready rises, the next acceptance happens in IDLE.
- Reset mid-op: assert rst_n low at MUL cycle 2 -> next cycle out_valid = 0, result = 0, in_ready = 1; a subsequent 3*5+7 operation returns 22.
- Parameter sweep: WIDTH=128/LIMB=32 (K=4) and WIDTH=64/LIMB=64 (K=1).
  - 50 random operations each, matching golden x*y + c.
  - Latency of K cycles checked for each configuration.
